// File: rtl/onehot_decoder_stream_pkg.sv
// Shared types and defaults for the one-hot decoder stream block.
package decoder_pkg;

  localparam int DEC_CODE_W = 2;

  typedef enum logic [1:0] {
    DEC_EMPTY = 2'd0,
    DEC_ONE   = 2'd1,
    DEC_FULL  = 2'd2
  } dec_state_e;

endpackage

// File: rtl/onehot_decoder_stream_if.sv
// Encoded-input / one-hot-output stream bundle; master drives the decoder, slave is the decoder.
interface onehot_decoder_stream_if
  import decoder_pkg::*;
#(
  parameter int CODE_W = DEC_CODE_W
);
  localparam int N_OUT = 2 ** CODE_W;

  logic [CODE_W-1:0] in_code;
  logic              in_en;
  logic              in_valid;
  logic              in_ready;
  logic [N_OUT-1:0]  out_onehot;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_code, in_en, in_valid, out_ready,
    input  in_ready, out_onehot, out_valid
  );

  modport slave (
    input  in_code, in_en, in_valid, out_ready,
    output in_ready, out_onehot, out_valid
  );

endinterface

// File: rtl/onehot_decoder_stream_dec_onehot.sv
// Combinational CODE_W-to-2**CODE_W one-hot decode; a cleared enable yields an all-zero vector.
module dec_onehot
  import decoder_pkg::*;
#(
  parameter  int CODE_W = DEC_CODE_W,
  localparam int N_OUT  = 2 ** CODE_W
) (
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [N_OUT-1:0]  onehot
);

  // Decode with enable.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[code] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/onehot_decoder_stream.sv
// Registered one-hot decoder with a 2-entry skid buffer on a valid/ready stream.
// Optional per-line saturating hit counters are built when DEC_HIT_CNT_EN is defined.
module onehot_decoder_stream
  import decoder_pkg::*;
#(
  parameter  int CODE_W = DEC_CODE_W,
  parameter  int CNT_W  = 8,
  localparam int N_OUT  = 2 ** CODE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_decoder_stream_if.slave   bus
`ifdef DEC_HIT_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [N_OUT*CNT_W-1:0]   hit_cnt
`endif
);

  dec_state_e       state_q, state_d;
  logic [N_OUT-1:0] head_q, head_d;
  logic [N_OUT-1:0] skid_q, skid_d;
  logic [N_OUT-1:0] dec_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  dec_onehot #(.CODE_W(CODE_W)) u_dec (
    .code   (bus.in_code),
    .en     (bus.in_en),
    .onehot (dec_s)
  );

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready_s     = (state_q != DEC_FULL) && !rst;
  assign out_valid_s    = (state_q != DEC_EMPTY);
  assign push_s         = bus.in_valid && in_ready_s;
  assign pop_s          = out_valid_s && bus.out_ready;
  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_onehot = head_q;

  // Next-state and storage update for the head/skid pair.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      DEC_EMPTY: begin
        if (push_s) begin
          state_d = DEC_ONE;
          head_d  = dec_s;
        end else begin
          state_d = DEC_EMPTY;
        end
      end
      DEC_ONE: begin
        if (push_s && !pop_s) begin
          state_d = DEC_FULL;
          skid_d  = dec_s;
        end else if (pop_s && !push_s) begin
          state_d = DEC_EMPTY;
          head_d  = '0;
        end else if (push_s && pop_s) begin
          state_d = DEC_ONE;
          head_d  = dec_s;
        end else begin
          state_d = DEC_ONE;
        end
      end
      DEC_FULL: begin
        if (pop_s) begin
          state_d = DEC_ONE;
          head_d  = skid_q;
        end else begin
          state_d = DEC_FULL;
        end
      end
      default: begin
        state_d = DEC_EMPTY;
        head_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEC_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DEC_HIT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_OUT*CNT_W-1:0] hit_q, hit_d;

  // Counts each nonzero output transfer on its line; clear has priority, values saturate.
  always_comb begin
    hit_d = hit_q;
    if (cnt_clr) begin
      hit_d = '0;
    end else if (pop_s) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (head_q[i] && (hit_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          hit_d[i*CNT_W +: CNT_W] = hit_q[i*CNT_W +: CNT_W] + CNT_ONE;
        end else begin
          hit_d[i*CNT_W +: CNT_W] = hit_q[i*CNT_W +: CNT_W];
        end
      end
    end else begin
      hit_d = hit_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed and table-driven bench for onehot_decoder_stream (counter checks under DEC_HIT_CNT_EN).
module tb_onehot_decoder_stream;

  localparam int CW    = 2;
  localparam int NO    = 4;
  localparam int CNTW  = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  onehot_decoder_stream_if #(.CODE_W(CW)) bus ();

`ifdef DEC_HIT_CNT_EN
  logic                 cnt_clr;
  logic [NO*CNTW-1:0]   hit_cnt;

  onehot_decoder_stream #(.CODE_W(CW), .CNT_W(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt)
  );
`else
  onehot_decoder_stream #(.CODE_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] q [$];
    logic [3:0] cur_exp;
    logic [3:0] prev_out;
    logic       prev_stall;
    logic [3:0] got;
    int         sent;
    int         recv;
    int         cyc;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.in_code   = 2'd0;
    bus.in_en     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef DEC_HIT_CNT_EN
    cnt_clr = 1'b0;
`endif

    vecs[0] = '{code: 2'd0, en: 1'b1, exp: 4'b0001};
    vecs[1] = '{code: 2'd1, en: 1'b1, exp: 4'b0010};
    vecs[2] = '{code: 2'd2, en: 1'b1, exp: 4'b0100};
    vecs[3] = '{code: 2'd3, en: 1'b1, exp: 4'b1000};
    vecs[4] = '{code: 2'd3, en: 1'b0, exp: 4'b0000};
    vecs[5] = '{code: 2'd2, en: 1'b0, exp: 4'b0000};

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_onehot", {28'd0, bus.out_onehot}, 32'd0);
`ifdef DEC_HIT_CNT_EN
    chk("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back table with out_ready high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = vecs[i].code;
      bus.in_en    = vecs[i].en;
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("tbl%0d_onehot", i), {28'd0, bus.out_onehot}, {28'd0, vecs[i].exp});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("tbl_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure fills skid
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_en     = 1'b1;
    bus.in_code   = 2'd1;
    tick();
    chk("bp_first_onehot", {28'd0, bus.out_onehot}, 32'h2);
    chk("bp_first_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_code = 2'd2;
    tick();
    chk("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_full_onehot", {28'd0, bus.out_onehot}, 32'h2);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_hold_onehot", {28'd0, bus.out_onehot}, 32'h2);
    chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_no_comb", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("bp_second_onehot", {28'd0, bus.out_onehot}, 32'h4);
    chk("bp_second_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_empty_valid", {31'd0, bus.out_valid}, 32'd0);

    // Random stalls, 200 words, scoreboard ordering
    sent       = 0;
    recv       = 0;
    prev_stall = 1'b0;
    prev_out   = 4'd0;
    bus.in_code  = 2'($urandom_range(3, 0));
    bus.in_en    = 1'($urandom_range(1, 0));
    bus.in_valid = 1'b1;
    for (cyc = 0; cyc < 3000 && recv < 200; cyc++) begin
      bus.out_ready = ($urandom_range(99, 0) < 60);
      @(negedge clk);
      if (prev_stall && bus.out_valid) begin
        chk("stall_stable", {28'd0, bus.out_onehot}, {28'd0, prev_out});
      end
      cur_exp = bus.in_en ? (4'b0001 << bus.in_code) : 4'b0000;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rnd_extra actual=%0h expected=none", bus.out_onehot);
        end else begin
          got = q.pop_front();
          chk($sformatf("rnd_word%0d", recv), {28'd0, bus.out_onehot}, {28'd0, got});
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_exp);
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out_onehot;
      @(posedge clk);
      #1;
      if (bus.in_valid && sent > 0 && q.size() > 0 && q[q.size()-1] == cur_exp && sent <= 200) begin
        bus.in_code = 2'($urandom_range(3, 0));
        bus.in_en   = 1'($urandom_range(1, 0));
      end
      if (sent >= 200) begin
        bus.in_valid = 1'b0;
      end
    end
    chk("rnd_recv_count", recv, 32'd200);
    chk("rnd_queue_empty", q.size(), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset while FULL
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_en     = 1'b1;
    bus.in_code   = 2'd3;
    tick();
    bus.in_code = 2'd0;
    tick();
    chk("full_before_rst", {31'd0, bus.in_ready}, 32'd0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("rstfull_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rstfull_onehot", {28'd0, bus.out_onehot}, 32'd0);
    chk("rstfull_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("rstfull_ignored_push", {31'd0, bus.out_valid}, 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rstfull_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("rstfull_rel_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef DEC_HIT_CNT_EN
    // Saturation on line 3
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_en     = 1'b1;
    bus.in_code   = 2'd3;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_sat_line3", {30'd0, hit_cnt[7:6]}, 32'd3);
    chk("cnt_sat_others", {26'd0, hit_cnt[5:0]}, 32'd0);
    // Clear coincident with a transfer
    bus.out_ready = 1'b0;
    bus.in_code   = 2'd1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cnt_clr       = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", {24'd0, hit_cnt}, 32'd0);
    chk("cnt_clr_popped", {31'd0, bus.out_valid}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_stream.md
# onehot_decoder_stream

Registered 2-to-4 one-hot decoder with a valid/ready stream interface. It sits at the receiving end of the 4-to-2 encoder path. It accepts an encoded line index plus the encoder's "any line active" flag, and regenerates the one-hot line vector. A 2-entry skid buffer gives full throughput under downstream backpressure.

## Interface
- `CODE_W`, default 2: encoded index width; output width is `N_OUT = 2**CODE_W`.
- `CNT_W`, default 8: width of each per-line hit counter (used only with `DEC_HIT_CNT_EN`).
- `clk` in, 1: single clock; all logic is rising-edge.
- `rst` in, 1: synchronous, active-high reset.
- `in_code` in, `CODE_W`: encoded line index.
- `in_en` in, 1: encoder valid flag; 0 means no line is active.
- `in_valid` in, 1: upstream word present.
- `in_ready` out, 1: decoder can accept.
- `out_onehot` out, `N_OUT`: decoded line vector.
- `out_valid` out, 1: output word present.
- `out_ready` in, 1: downstream accepts.
- `cnt_clr` in, 1: synchronous clear of hit counters (`DEC_HIT_CNT_EN` only).
- `hit_cnt` out, `N_OUT*CNT_W`: packed per-line counters; line i occupies bits `[i*CNT_W +: CNT_W]` (`DEC_HIT_CNT_EN` only).

## Operation
- Decode rule: `in_en=1` gives `out_onehot = 1 << in_code`. `in_en=0` gives all zeros, regardless of `in_code`. A zero word is still a valid transfer.
- Input handshake: a word is accepted on a cycle with `in_valid && in_ready`.
- Output handshake: a word is consumed on a cycle with `out_valid && out_ready`.
- Storage: a head register drives the outputs, and a skid register sits behind it. Words are decoded before storage.
- FSM states: EMPTY, ONE, FULL.
  - EMPTY, push: go to ONE; the word loads into head.
  - ONE, push and no pop: go to FULL; the word loads into skid.
  - ONE, pop and no push: go to EMPTY.
  - ONE, push and pop together: stay in ONE; the new word loads into head.
  - FULL, pop: go to ONE; skid moves to head. No push is possible in FULL.
  - All other cases hold state.
- `out_valid` is 1 when state is not EMPTY. `in_ready` is 1 when state is not FULL and `rst` is 0.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Out-of-range codes are impossible by construction, since `N_OUT = 2**CODE_W`.

## Timing
- Reset values: state EMPTY, `out_onehot = 0`, `out_valid = 0`, `hit_cnt = 0`. `in_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- Reset mid-operation discards both stored words on the next edge. Handshakes seen during `rst` are ignored.
- Latency: a word accepted at edge k is visible at `out_*` after edge k (one-cycle latency).
- Throughput: one word per cycle while `out_ready` is held high.
- `out_onehot` is stable while `out_valid && !out_ready`.
- `in_ready` is a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `DEC_HIT_CNT_EN` defined:
  - `cnt_clr` and `hit_cnt` ports exist.
  - On each output transfer with a nonzero word, the counter for the set line increments.
  - Counters saturate at `2**CNT_W-1`.
  - If `cnt_clr` and an increment happen in the same cycle, the clear wins.
  - `rst` clears all counters.
- `DEC_HIT_CNT_EN` undefined: the ports and counters are absent. Datapath behaviour is identical.

## Structure
- `decoder_pkg` holds the FSM state enum (`DEC_EMPTY`, `DEC_ONE`, `DEC_FULL`) and the `CODE_W` default constant.
- Sub-module `dec_onehot` is the purely combinational `CODE_W`-to-`N_OUT` decode with enable. It is instantiated once, on the input side.

## Test plan
- Reset, then `in_en=1` with codes 0, 1, 2, 3 back-to-back and `out_ready=1` -> outputs 0001, 0010, 0100, 1000 on consecutive cycles, one cycle after each accept.
- `in_en=0` with `in_code=2'b11` -> one transfer with `out_onehot = 0000` and `out_valid = 1`.
- `out_ready=0`, then push codes 1 and 2 -> `in_ready=0` after the second accept and output holds 0010. Raise `out_ready` -> 0010 then 0100, and `in_ready` returns to 1.
- Random `out_ready` stall pattern over 200 words -> output sequence equals the input sequence, decoded in order, with none lost or duplicated.
- Assert `rst` while in FULL -> next cycle `out_valid=0`, `out_onehot=0`, `in_ready=0`; after release `in_ready=1`.
- With `DEC_HIT_CNT_EN` and `CNT_W=2`:
  - Send code 3 five times -> `hit_cnt` for line 3 reads 3 (saturated); other lines read 0.
  - `cnt_clr` coincident with a transfer -> all counters read 0.
